bit_reservoir_fifo: RTL and testbench
=====================================

// Module: bit_reservoir_fifo
// PURPOSE
//  Parametrised bit-granular FIFO for the MP3 parser: accepts DIN_W-bit words (bytes from the
//  file reader) and returns a variable count of 1..DOUT_W bits per read, MSB-first bitstream order.
//  It replaces the single-bit-out FIFO and serves as the bit reservoir feeding side-info and
//  Huffman field extraction.
//  Adds full/space handling, circular wrap, variable read length, flush and error pulses.
// PARAMETERS
//  DIN_W   8      bits per write word
//  DOUT_W  32     max bits per read; dout width
//  DEPTH   16384  storage in bits; power of two, multiple of DIN_W, >= DOUT_W
//  LEN_W   $clog2(DOUT_W+1)  width of rd_len (derived)
//  CNT_W   $clog2(DEPTH+1)   width of dcount_out (derived)
// PORTS
//  clk            in   1       system clock, all logic on posedge
//  srst_n         in   1       synchronous active-low reset
//  flush          in   1       discard all contents (frame resync)
//  din            in   DIN_W   write word; din[DIN_W-1] is the earliest bit in stream order
//  wr_en          in   1       write request
//  wr_ready       out  1       combinational: dcount_out <= DEPTH-DIN_W
//  rd_en          in   1       read request
//  rd_len         in   LEN_W   number of bits requested, legal 1..DOUT_W
//  dout           out  DOUT_W  read data, right-aligned, upper bits zero
//  dout_valid     out  1       dout holds data of the read accepted last cycle
//  dcount_out     out  CNT_W   bits currently stored
//  overflow_err   out  1       1-cycle pulse: write dropped
//  underflow_err  out  1       1-cycle pulse: read rejected
// BEHAVIOUR
//  - Reset (srst_n=0 at posedge): wr_ptr, rd_ptr, dcount_out, dout, dout_valid, both errs <= 0.
//    Storage contents need not be cleared.
//  - Priority per cycle: reset > flush > read/write.
//  - flush=1: pointers and count <= 0, dout <= 0, dout_valid <= 0, errs <= 0.
//    Same-cycle wr_en and rd_en are ignored without raising an error.
//  - Write accept: wr_en && wr_ready, evaluated on the pre-update count.
//    A same-cycle read does not create space.
//    Accepted: din stored at bits wr_ptr..wr_ptr+DIN_W-1 (mod DEPTH), MSB first;
//    wr_ptr += DIN_W (mod DEPTH).
//    Refused: data dropped, overflow_err=1 next cycle, state unchanged.
//  - Read accept: rd_en && 1<=rd_len<=DOUT_W && dcount_out>=rd_len, evaluated on the
//    pre-update count. Bits written in the same cycle are not readable.
//    Accepted: next cycle dout[rd_len-1:0] holds stream bits rd_ptr..rd_ptr+rd_len-1
//    (earliest bit in dout[rd_len-1]), dout[DOUT_W-1:rd_len]=0, dout_valid=1;
//    rd_ptr += rd_len (mod DEPTH).
//    Refused (short count or illegal rd_len): dout=0, dout_valid=0, underflow_err=1 next cycle,
//    state unchanged.
//  - No rd_en: dout=0, dout_valid=0. Read latency is exactly 1 cycle; no back-pressure on dout.
//  - Count update: dcount_out += (wr_acc ? DIN_W : 0) - (rd_acc ? rd_len : 0);
//    both may occur in the same cycle.
//  - Wrap: any read or write may straddle DEPTH-1 -> 0 and must return contiguous stream data.
//  - Full: dcount_out = DEPTH is reachable, and wr_ready=0 whenever fewer than DIN_W bits are free.
//  - Empty: dcount_out = 0; any read is refused.
// TESTING
//  1 Reset: hold srst_n=0 for 2 cycles mid-traffic -> dcount_out=0, wr_ready=1, dout_valid=0,
//    dout=0, errs=0.
//  2 Write 0xA5 then 0x3C; read len 4, then 8, then 4 -> dout=0x0000000A, then 0x0000005 3,
//    then 0x0000000C. Each is valid 1 cycle after its request; dcount_out ends at 0.
//  3 Count=3, read len 4 -> dout_valid=0, underflow_err pulses once, dcount_out stays 3.
//    Read len 0 and len 33 -> also rejected.
//  4 Write 2048 bytes -> dcount_out=16384, wr_ready=0. Next write -> overflow_err pulses, count
//    unchanged. Read 32 bits, then write 0x81 (straddles wrap). Drain fully -> data matches the
//    reference model bit-for-bit.
//  5 Count=8: wr_en with 0xFF plus rd_en len 5 in the same cycle -> dcount_out=11.
//    Count=0: same-cycle write plus read len 1 -> read refused, dcount_out=8.
//  6 Flush asserted with wr_en and rd_en, count=100 -> next cycle dcount_out=0, dout_valid=0,
//    no error pulses. Then write 0x80, read len 1 -> dout=1.

Source files
------------

// File: rtl/bit_reservoir_fifo.sv
// Bit-granular reservoir FIFO: DIN_W-bit words in, 1..DOUT_W bits out per read, MSB-first stream.
// Storage is word-addressed; reads gather a window of consecutive words and shift out the bit span.
module bit_reservoir_fifo #(
  parameter int unsigned DIN_W  = 8,
  parameter int unsigned DOUT_W = 32,
  parameter int unsigned DEPTH  = 16384,
  parameter int unsigned LEN_W  = $clog2(DOUT_W + 1),
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic              flush,
  input  logic [DIN_W-1:0]  din,
  input  logic              wr_en,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [LEN_W-1:0]  rd_len,
  output logic [DOUT_W-1:0] dout,
  output logic              dout_valid,
  output logic [CNT_W-1:0]  dcount_out,
  output logic              overflow_err,
  output logic              underflow_err
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned WORDS   = DEPTH / DIN_W;
  localparam int unsigned WADDR_W = $clog2(WORDS);
  localparam int unsigned NWIN    = (DOUT_W + DIN_W - 1) / DIN_W + 1;
  localparam int unsigned WIN_W   = NWIN * DIN_W;
  localparam int unsigned SH_W    = $clog2(WIN_W + 1);

  logic [DIN_W-1:0]   mem_q [WORDS];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DOUT_W-1:0]  dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;

  logic [WADDR_W-1:0] rd_word_c, wr_word_c;
  logic [SH_W-1:0]    rd_off_c;
  logic [WIN_W-1:0]   win_c, win_sh_c;
  logic [DOUT_W-1:0]  rd_data_c;
  logic               wr_acc_c, rd_acc_c, rd_len_ok_c, mem_we_c;

  assign wr_ready      = (cnt_q <= CNT_W'(DEPTH - DIN_W));
  assign dout          = dout_q;
  assign dout_valid    = dout_valid_q;
  assign dcount_out    = cnt_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = udf_q;

  assign rd_word_c = WADDR_W'(rd_ptr_q / PTR_W'(DIN_W));
  assign wr_word_c = WADDR_W'(wr_ptr_q / PTR_W'(DIN_W));
  assign rd_off_c  = SH_W'(rd_ptr_q % PTR_W'(DIN_W));

  // Window of NWIN consecutive words starting at the read word, earliest word in the MSBs
  always_comb begin
    win_c = '0;
    for (int unsigned k = 0; k < NWIN; k++) begin
      win_c = (win_c << DIN_W) | WIN_W'(mem_q[rd_word_c + WADDR_W'(k)]);
    end
  end

  // Drop bits before rd_ptr, then right-align the requested span
  assign win_sh_c  = win_c << rd_off_c;
  assign rd_data_c = DOUT_W'(win_sh_c >> (SH_W'(WIN_W) - SH_W'(rd_len)));

  assign rd_len_ok_c = (rd_len != '0) && (rd_len <= LEN_W'(DOUT_W));
  assign wr_acc_c    = wr_en && wr_ready;
  assign rd_acc_c    = rd_en && rd_len_ok_c && (cnt_q >= CNT_W'(rd_len));
  assign mem_we_c    = srst_n && !flush && wr_acc_c;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    dout_d       = '0;
    dout_valid_d = 1'b0;
    ovf_d        = 1'b0;
    udf_d        = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_acc_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(DIN_W);
      end else if (wr_en) begin
        ovf_d = 1'b1;
      end
      if (rd_acc_c) begin
        rd_ptr_d     = rd_ptr_q + PTR_W'(rd_len);
        dout_d       = rd_data_c;
        dout_valid_d = 1'b1;
      end else if (rd_en) begin
        udf_d = 1'b1;
      end
      cnt_d = cnt_q + (wr_acc_c ? CNT_W'(DIN_W) : '0) - (rd_acc_c ? CNT_W'(rd_len) : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
    end
  end

  // Storage needs no reset; stale words are never exposed because the count gates reads
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[wr_word_c] <= din;
    end
  end

endmodule

// File: tb/tb_bit_reservoir_fifo.sv
// Bench for bit_reservoir_fifo: bit-queue reference model with a scoreboard of expected read data.
`timescale 1ns/1ps
module tb_bit_reservoir_fifo;

  localparam int unsigned DIN_W  = 8;
  localparam int unsigned DOUT_W = 32;
  localparam int unsigned DEPTH  = 16384;
  localparam int unsigned LEN_W  = 6;
  localparam int unsigned CNT_W  = 15;

  logic              clk;
  logic              srst_n;
  logic              flush;
  logic [DIN_W-1:0]  din;
  logic              wr_en;
  logic              wr_ready;
  logic              rd_en;
  logic [LEN_W-1:0]  rd_len;
  logic [DOUT_W-1:0] dout;
  logic              dout_valid;
  logic [CNT_W-1:0]  dcount_out;
  logic              overflow_err;
  logic              underflow_err;

  bit_reservoir_fifo #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .srst_n(srst_n), .flush(flush), .din(din), .wr_en(wr_en),
    .wr_ready(wr_ready), .rd_en(rd_en), .rd_len(rd_len), .dout(dout),
    .dout_valid(dout_valid), .dcount_out(dcount_out),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  string phase = "init";
  bit model_q[$];
  logic [DOUT_W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL [%s] %s: got 0x%0h expected 0x%0h", phase, tag, got, exp);
    end
  endtask

  // One cycle of stimulus, starting and ending at a negedge
  task automatic drive(input logic w, input logic [DIN_W-1:0] d, input logic r,
                       input logic [LEN_W-1:0] l, input logic f);
    logic wa, ra;
    logic [DOUT_W-1:0] v;
    int unsigned sz;
    sz = model_q.size();
    wr_en = w; din = d; rd_en = r; rd_len = l; flush = f;
    check_eq("wr_ready", wr_ready, sz <= DEPTH - DIN_W);
    wa = !f && w && (sz <= DEPTH - DIN_W);
    ra = !f && r && (l >= 1) && (l <= DOUT_W) && (sz >= l);
    if (ra) begin
      v = '0;
      for (int i = 0; i < int'(l); i++) v = {v[DOUT_W-2:0], model_q.pop_front()};
      exp_q.push_back(v);
    end
    if (wa) for (int i = DIN_W - 1; i >= 0; i--) model_q.push_back(d[i]);
    if (f) model_q.delete();
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; rd_len = '0; din = '0;
    check_eq("dout_valid", dout_valid, ra);
    if (ra) check_eq("dout", dout, exp_q.pop_front());
    else    check_eq("dout_idle", dout, '0);
    check_eq("overflow_err", overflow_err, !f && w && !wa);
    check_eq("underflow_err", underflow_err, !f && r && !ra);
    check_eq("dcount", dcount_out, model_q.size());
    @(negedge clk);
  endtask

  task automatic do_reset();
    srst_n = 1'b0; wr_en = 1'b1; din = 8'h5A; rd_en = 1'b1; rd_len = 6'd4;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_dcount", dcount_out, '0);
    check_eq("rst_wr_ready", wr_ready, 1'b1);
    check_eq("rst_dout_valid", dout_valid, 1'b0);
    check_eq("rst_dout", dout, '0);
    check_eq("rst_ovf", overflow_err, 1'b0);
    check_eq("rst_udf", underflow_err, 1'b0);
    @(negedge clk);
    srst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0; rd_len = '0; din = '0;
    model_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned len;
    srst_n = 1'b0; flush = 1'b0; din = '0; wr_en = 1'b0; rd_en = 1'b0; rd_len = '0;
    @(negedge clk);
    phase = "reset";
    do_reset();
    drive(1, 8'h12, 0, 0, 0);
    drive(1, 8'h34, 1, 5, 0);
    drive(1, 8'h56, 1, 7, 0);
    do_reset();

    phase = "basic";
    drive(1, 8'hA5, 0, 0, 0);
    drive(1, 8'h3C, 0, 0, 0);
    drive(0, 0, 1, 4, 0);
    check_eq("t2_len4", dout, 32'h0000_000A);
    drive(0, 0, 1, 8, 0);
    check_eq("t2_len8", dout, 32'h0000_0053);
    drive(0, 0, 1, 4, 0);
    check_eq("t2_len4b", dout, 32'h0000_000C);
    check_eq("t2_empty", dcount_out, 0);

    phase = "underflow";
    drive(1, 8'hF0, 0, 0, 0);
    drive(0, 0, 1, 5, 0);
    drive(0, 0, 1, 4, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 33, 0);
    check_eq("t3_cnt3", dcount_out, 3);
    drive(0, 0, 1, 3, 0);
    drive(0, 0, 1, 1, 0);

    phase = "full_wrap";
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH / DIN_W; i++) drive(1, DIN_W'($urandom), 0, 0, 0);
    check_eq("t4_full", dcount_out, DEPTH);
    check_eq("t4_wr_ready", wr_ready, 1'b0);
    drive(1, 8'h55, 0, 0, 0);
    drive(0, 0, 1, 32, 0);
    drive(1, 8'h81, 0, 0, 0);
    while (model_q.size() > 0) begin
      len = $urandom_range(1, DOUT_W);
      if (len > model_q.size()) len = model_q.size();
      drive(0, 0, 1, LEN_W'(len), 0);
    end

    phase = "same_cycle";
    drive(1, 8'h6B, 0, 0, 0);
    drive(1, 8'hFF, 1, 5, 0);
    check_eq("t5_cnt11", dcount_out, 11);
    drive(0, 0, 1, 11, 0);
    drive(1, 8'hC3, 1, 1, 0);
    check_eq("t5_cnt8", dcount_out, 8);
    drive(0, 0, 1, 8, 0);

    phase = "flush";
    for (int i = 0; i < 13; i++) drive(1, DIN_W'($urandom), 0, 0, 0);
    drive(0, 0, 1, 4, 0);
    check_eq("t6_cnt100", dcount_out, 100);
    drive(1, 8'h77, 1, 8, 1);
    check_eq("t6_flushed", dcount_out, 0);
    drive(1, 8'h80, 0, 0, 0);
    drive(0, 0, 1, 1, 0);
    check_eq("t6_bit", dout, 32'h1);

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), DIN_W'($urandom), 1'($urandom_range(0, 1)),
            LEN_W'($urandom_range(0, 33)), 1'($urandom_range(0, 63) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
